// File: rtl/immgen_pkg.sv
// rtl/immgen_pkg.sv - opcode constants and format tags shared by the immediate generator
package immgen_pkg;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_OP32    = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

  function automatic logic is_shift_f3(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/immgen_decode.sv
// rtl/immgen_decode.sv - combinational instruction-to-immediate decoder
module immgen_decode
  import immgen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam int SH_W = (XLEN == 64) ? 6 : 5;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] shamt_native;
  logic [XLEN-1:0] shamt_w;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  // Word shifts (OP-IMM-32) only ever have a 5-bit shift amount.
  assign shamt_native = XLEN'(instr[20 +: SH_W]);
  assign shamt_w      = XLEN'(instr[24:20]);

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        fmt = FMT_I;
        imm = imm_i;
      end
      OP_OPIMM: begin
        if (is_shift_f3(funct3)) begin
          fmt = FMT_SHAMT;
          imm = shamt_native;
        end else begin
          fmt = FMT_I;
          imm = imm_i;
        end
      end
      OP_OPIMM32: begin
        if (XLEN != 64) begin
          illegal = 1'b1;
        end else if (is_shift_f3(funct3)) begin
          fmt = FMT_SHAMT;
          imm = shamt_w;
        end else begin
          fmt = FMT_I;
          imm = imm_i;
        end
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = imm_s;
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        imm = imm_b;
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        imm = imm_u;
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = imm_j;
      end
      OP_OP, OP_OP32: begin
        fmt = FMT_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/immgen_pipe.sv
// rtl/immgen_pipe.sv - registered immediate generator with a 2-entry skid buffer
module immgen_pipe
  import immgen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t dec_entry;
  entry_t main_d, main_q;
  entry_t skid_d, skid_q;
  logic   main_valid_d, main_valid_q;
  logic   skid_valid_d, skid_valid_q;
  logic   in_fire;
  logic   out_fire;

  immgen_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_entry.imm),
    .fmt     (dec_entry.fmt),
    .illegal (dec_entry.illegal)
  );
  assign dec_entry.pc = in_pc;

  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      // A full skid implies in_ready was low, so no new input competes for main.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = dec_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_immgen_pipe.sv
// tb/tb_immgen_pipe.sv - scoreboard bench driving XLEN=32 and XLEN=64 instances in lockstep
module tb_immgen_pipe;
  import immgen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_pc32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_pc64;
  logic [2:0]  out_fmt64;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_ready = 1'b0;
  logic [31:0] pc_ctr = 32'h1000;

  always #5 clk = ~clk;

  immgen_pipe #(.XLEN(32), .PC_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_pc(out_pc32)
  );

  immgen_pipe #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_pc(out_pc64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc, input bit is64);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [63:0] sx_i, sx_s, sx_b, sx_u, sx_j;
    opc  = ins[6:0];
    f3   = ins[14:12];
    sx_i = {{52{ins[31]}}, ins[31:20]};
    sx_s = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    sx_b = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    sx_u = {{32{ins[31]}}, ins[31:12], 12'h000};
    sx_j = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e.imm = 64'd0; e.fmt = FMT_NONE; e.ill = 1'b0; e.pc = pc;
    case (opc)
      7'h03, 7'h67: begin e.fmt = FMT_I; e.imm = sx_i; end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.fmt = FMT_SHAMT;
          e.imm = is64 ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
        end else begin
          e.fmt = FMT_I; e.imm = sx_i;
        end
      end
      7'h1B: begin
        if (!is64) e.ill = 1'b1;
        else if (f3 == 3'd1 || f3 == 3'd5) begin e.fmt = FMT_SHAMT; e.imm = {59'd0, ins[24:20]}; end
        else begin e.fmt = FMT_I; e.imm = sx_i; end
      end
      7'h23: begin e.fmt = FMT_S; e.imm = sx_s; end
      7'h63: begin e.fmt = FMT_B; e.imm = sx_b; end
      7'h37, 7'h17: begin e.fmt = FMT_U; e.imm = sx_u; end
      7'h6F: begin e.fmt = FMT_J; e.imm = sx_j; end
      7'h33, 7'h3B: ;
      default: e.ill = 1'b1;
    endcase
    if (!is64) e.imm = {32'd0, e.imm[31:0]};
    return e;
  endfunction

  // Outputs are compared against the queue head on every valid cycle, so a
  // stalled entry that changes is caught as well as a wrong final value.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q32.delete();
      q64.delete();
    end else begin
      if (out_valid32) begin
        if (q32.size() == 0) check("sb32_unexpected_out", 64'd1, 64'd0);
        else begin
          e = q32[0];
          check("sb32_imm", {32'd0, out_imm32}, e.imm);
          check("sb32_fmt", {61'd0, out_fmt32}, {61'd0, e.fmt});
          check("sb32_ill", {63'd0, out_illegal32}, {63'd0, e.ill});
          check("sb32_pc", {32'd0, out_pc32}, {32'd0, e.pc});
          if (out_ready) void'(q32.pop_front());
        end
      end
      if (out_valid64) begin
        if (q64.size() == 0) check("sb64_unexpected_out", 64'd1, 64'd0);
        else begin
          e = q64[0];
          check("sb64_imm", out_imm64, e.imm);
          check("sb64_fmt", {61'd0, out_fmt64}, {61'd0, e.fmt});
          check("sb64_ill", {63'd0, out_illegal64}, {63'd0, e.ill});
          check("sb64_pc", {32'd0, out_pc64}, {32'd0, e.pc});
          if (out_ready) void'(q64.pop_front());
        end
      end
      if (flush) begin
        q32.delete();
        q64.delete();
      end else if (in_valid) begin
        if (in_ready32) q32.push_back(ref_dec(in_instr, in_pc, 1'b0));
        if (in_ready64) q64.push_back(ref_dec(in_instr, in_pc, 1'b1));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    int n;
    bit acc;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc_ctr;
    pc_ctr   = pc_ctr + 32'd4;
    n = 0;
    do begin
      acc = in_ready32;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((out_valid32 || out_valid64) && n < 50) begin
      step();
      n++;
    end
    check("drain_done", {63'd0, out_valid32 | out_valid64}, 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ov32"}, {63'd0, out_valid32}, 64'd0);
    check({tag, "_ir32"}, {63'd0, in_ready32}, 64'd1);
    check({tag, "_imm32"}, {32'd0, out_imm32}, 64'd0);
    check({tag, "_fmt32"}, {61'd0, out_fmt32}, {61'd0, FMT_NONE});
    check({tag, "_ill32"}, {63'd0, out_illegal32}, 64'd0);
    check({tag, "_pc32"}, {32'd0, out_pc32}, 64'd0);
    check({tag, "_ov64"}, {63'd0, out_valid64}, 64'd0);
    check({tag, "_ir64"}, {63'd0, in_ready64}, 64'd1);
    check({tag, "_imm64"}, out_imm64, 64'd0);
    check({tag, "_fmt64"}, {61'd0, out_fmt64}, {61'd0, FMT_NONE});
    check({tag, "_pc64"}, {32'd0, out_pc64}, 64'd0);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [63:0] e32;
    logic [2:0]  f32;
    logic        i32;
    logic [63:0] e64;
    logic [2:0]  f64;
    logic        i64;
  } dir_t;

  dir_t dir_tab[9];
  logic [6:0] ops[13];

  initial begin
    dir_tab[0] = '{32'h0F012083, 64'd240, FMT_I, 1'b0, 64'd240, FMT_I, 1'b0};
    dir_tab[1] = '{32'h8C112023, 64'hFFFFF8C0, FMT_S, 1'b0, 64'hFFFFFFFFFFFFF8C0, FMT_S, 1'b0};
    dir_tab[2] = '{32'h64000963, 64'd1618, FMT_B, 1'b0, 64'd1618, FMT_B, 1'b0};
    dir_tab[3] = '{32'hFFDFF06F, 64'hFFFFFFFC, FMT_J, 1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_J, 1'b0};
    dir_tab[4] = '{32'h123450B7, 64'h12345000, FMT_U, 1'b0, 64'h12345000, FMT_U, 1'b0};
    dir_tab[5] = '{32'h0000007F, 64'd0, FMT_NONE, 1'b1, 64'd0, FMT_NONE, 1'b1};
    dir_tab[6] = '{32'h800000B7, 64'h80000000, FMT_U, 1'b0, 64'hFFFFFFFF80000000, FMT_U, 1'b0};
    dir_tab[7] = '{32'h02801093, 64'd8, FMT_SHAMT, 1'b0, 64'd40, FMT_SHAMT, 1'b0};
    dir_tab[8] = '{32'hFFF0009B, 64'd0, FMT_NONE, 1'b1, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0};
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h0B};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    step();
    step();
    check_reset_state("reset");
    rst_n = 1'b1;
    step();

    // Back-to-back directed stream: each result must be on out_* the cycle after acceptance.
    for (int i = 0; i < 9; i++) begin
      send(dir_tab[i].ins);
      check("dir_valid32", {63'd0, out_valid32}, 64'd1);
      check("dir_imm32", {32'd0, out_imm32}, dir_tab[i].e32);
      check("dir_fmt32", {61'd0, out_fmt32}, {61'd0, dir_tab[i].f32});
      check("dir_ill32", {63'd0, out_illegal32}, {63'd0, dir_tab[i].i32});
      check("dir_imm64", out_imm64, dir_tab[i].e64);
      check("dir_fmt64", {61'd0, out_fmt64}, {61'd0, dir_tab[i].f64});
      check("dir_ill64", {63'd0, out_illegal64}, {63'd0, dir_tab[i].i64});
    end
    drain();

    // Backpressure: two accepted, third held until the skid drains.
    out_ready = 1'b0;
    send(32'h00500093);
    send(32'hFFB00113);
    check("bp_ready_low", {63'd0, in_ready32}, 64'd0);
    in_valid = 1'b1; in_instr = 32'h00C02183; in_pc = pc_ctr; pc_ctr = pc_ctr + 32'd4;
    step();
    check("bp_third_blocked", {63'd0, in_ready32}, 64'd0);
    step();
    step();
    check("bp_still_blocked", {63'd0, in_ready64}, 64'd0);
    out_ready = 1'b1;
    step();
    check("bp_ready_back", {63'd0, in_ready32}, 64'd1);
    check("bp_out_valid", {63'd0, out_valid32}, 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_third_in_main", {32'd0, out_imm32}, 64'd12);
    drain();

    // Flush with both entries full and an instruction offered in the same cycle.
    out_ready = 1'b0;
    send(32'h00100093);
    send(32'h00200093);
    in_valid = 1'b1; in_instr = 32'h7FF00093; in_pc = 32'hDEAD0000;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_ov32", {63'd0, out_valid32}, 64'd0);
    check("flush_ir32", {63'd0, in_ready32}, 64'd1);
    check("flush_ov64", {63'd0, out_valid64}, 64'd0);
    check("flush_ir64", {63'd0, in_ready64}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_stays_empty", {63'd0, out_valid32 | out_valid64}, 64'd0);
    end

    // Randomised traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] r;
      r = $urandom();
      r[6:0] = ops[$urandom_range(0, 12)];
      send(r);
      if (($urandom() & 3) == 0) begin
        in_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    rand_ready = 1'b0;
    drain();

    // Reset mid-stream overrides everything, including a concurrent flush.
    out_ready = 1'b0;
    send(32'h12345037);
    send(32'h00000463);
    in_valid = 1'b1; in_instr = 32'h0000006F;
    rst_n = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_reset_state("midrst");
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    check("final_q32_empty", 64'(q32.size()), 64'd0);
    check("final_q64_empty", 64'(q64.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
